// File: rtl/sc_scbc_regsel_pkg.sv
// Shared types and address decode for the SCBC register-bus slave selector.
package sc_scbc_regsel_pkg;

  localparam int unsigned MAX_SLV = 16;
  localparam int unsigned MAX_AW  = 64;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned DATA_W  = 32;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_WAIT = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Tables are widened to MAX_SLV x MAX_AW; empty slots carry a base that can never match.
  // Scanning downward lets the lowest matching index overwrite the result last.
  function automatic dec_t slv_decode(input logic [MAX_AW-1:0]         addr,
                                      input logic [MAX_SLV*MAX_AW-1:0] base,
                                      input logic [MAX_SLV*MAX_AW-1:0] mask);
    dec_t r;
    r = '0;
    for (int i = int'(MAX_SLV) - 1; i >= 0; i--) begin
      if ((addr & mask[i*MAX_AW +: MAX_AW]) == base[i*MAX_AW +: MAX_AW]) begin
        r.hit = 1'b1;
        r.idx = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_scbc_regsel_chan.sv
// One request channel: zero-wait select for synchronous slaves, req/ack with timeout otherwise.
module sc_scbc_regsel_chan
  import sc_scbc_regsel_pkg::*;
#(
  parameter int unsigned        NUM_SLV    = 4,
  parameter logic [NUM_SLV-1:0] ASYNC_MASK = '0,
  parameter int unsigned        TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic                      hit,
  input  logic [IDX_W-1:0]          idx,
  input  logic [NUM_SLV-1:0]        ack,
  input  logic [NUM_SLV*DATA_W-1:0] slv_rdat,
  output logic [NUM_SLV-1:0]        sel_c,
  output logic [NUM_SLV-1:0]        slv_req,
  output logic                      wat_c,
  output logic                      err_c,
  output logic [DATA_W-1:0]         rdat_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  ch_state_e           state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdat_q;
  logic [NUM_SLV-1:0]  req_q;

  logic [NUM_SLV-1:0]  dec_oh, lat_oh;
  logic                hit_async;
  logic [DATA_W-1:0]   dec_data, lat_data;
  logic                ack_sel;
  logic                tmo;

  // One-hot and data muxes for the live decode and for the latched slave
  always_comb begin
    dec_oh    = '0;
    lat_oh    = '0;
    hit_async = 1'b0;
    dec_data  = '0;
    lat_data  = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx == IDX_W'(i)) begin
        dec_oh[i] = 1'b1;
        hit_async = ASYNC_MASK[i];
        dec_data  = slv_rdat[i*DATA_W +: DATA_W];
      end
      if (idx_q == IDX_W'(i)) begin
        lat_oh[i] = 1'b1;
        lat_data  = slv_rdat[i*DATA_W +: DATA_W];
      end
    end
    ack_sel = |(ack & lat_oh);
    tmo     = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CH_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CH_IDLE: if (req && hit && hit_async) state_d = CH_WAIT;
      CH_WAIT: if (ack_sel || tmo)          state_d = CH_DONE;
      CH_DONE:                              state_d = CH_IDLE;
      default:                              state_d = CH_IDLE;
    endcase
  end

  always_comb begin
    sel_c  = '0;
    wat_c  = 1'b0;
    err_c  = 1'b0;
    rdat_c = '0;
    case (state_q)
      CH_IDLE: begin
        if (req) begin
          if (!hit) begin
            err_c = 1'b1;
          end else if (hit_async) begin
            wat_c = 1'b1;
          end else begin
            sel_c  = dec_oh;
            rdat_c = dec_data;
          end
        end
      end
      CH_WAIT: wat_c = 1'b1;
      CH_DONE: begin
        err_c  = err_q;
        rdat_c = rdat_q;
      end
      default: ;
    endcase
  end

  // Handshake datapath: latched slave, wait counter, completion status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      rdat_q <= '0;
      req_q  <= '0;
    end else begin
      if (state_d == CH_WAIT) req_q <= (state_q == CH_IDLE) ? dec_oh : lat_oh;
      else                    req_q <= '0;
      if (state_q == CH_IDLE && state_d == CH_WAIT) begin
        idx_q <= idx;
        cnt_q <= '0;
      end else if (state_q == CH_WAIT) begin
        if (ack_sel) begin
          err_q  <= 1'b0;
          rdat_q <= lat_data;
        end else if (tmo) begin
          err_q  <= 1'b1;
          rdat_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign slv_req = req_q;

endmodule

// File: rtl/sc_scbc_regsel.sv
// Register-bus slave selector: decodes write and read accesses onto a base/mask slave table.
module sc_scbc_regsel
  import sc_scbc_regsel_pkg::*;
#(
  parameter int unsigned                     ADDR_WIDTH = 32,
  parameter int unsigned                     NUM_SLV    = 4,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0]   SLV_BASE   = {NUM_SLV{ADDR_WIDTH'(0)}},
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0]   SLV_MASK   = {NUM_SLV{ADDR_WIDTH'(32'hFFFF_F000)}},
  parameter logic [NUM_SLV-1:0]              ASYNC_MASK = '0,
  parameter int unsigned                     TIMEOUT    = 255
) (
  input  logic                      SYSCLK,
  input  logic                      SYSRSTB,
  input  logic [ADDR_WIDTH-1:0]     REG_WADR,
  input  logic [3:0]                REG_WENB,
  input  logic [DATA_W-1:0]         REG_WDAT,
  output logic                      REG_WWAT,
  output logic                      REG_WERR,
  input  logic [ADDR_WIDTH-1:0]     REG_RADR,
  input  logic                      REG_RENB,
  output logic [DATA_W-1:0]         REG_RDAT,
  output logic                      REG_RWAT,
  output logic                      REG_RERR,
  output logic [NUM_SLV-1:0]        S_WSEL,
  output logic [NUM_SLV-1:0]        S_WREQ,
  input  logic [NUM_SLV-1:0]        S_WACK,
  output logic [ADDR_WIDTH-1:0]     S_WADR,
  output logic [DATA_W-1:0]         S_WDAT,
  output logic [3:0]                S_WENB,
  output logic [NUM_SLV-1:0]        S_RSEL,
  output logic [NUM_SLV-1:0]        S_RREQ,
  input  logic [NUM_SLV-1:0]        S_RACK,
  output logic [ADDR_WIDTH-1:0]     S_RADR,
  input  logic [NUM_SLV*DATA_W-1:0] S_RDAT
);

  // Widen the slave table to the decoder's fixed geometry
  function automatic logic [MAX_SLV*MAX_AW-1:0] ext_tbl(input logic [NUM_SLV*ADDR_WIDTH-1:0] t,
                                                        input logic fill);
    logic [MAX_SLV*MAX_AW-1:0] r;
    r = fill ? '1 : '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      r[i*MAX_AW +: MAX_AW] = MAX_AW'(t[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    return r;
  endfunction

  localparam logic [MAX_SLV*MAX_AW-1:0] BASE_EXT = ext_tbl(SLV_BASE, 1'b1);
  localparam logic [MAX_SLV*MAX_AW-1:0] MASK_EXT = ext_tbl(SLV_MASK, 1'b0);

  dec_t                      wdec, rdec;
  logic [NUM_SLV*DATA_W-1:0] wr_rdat_zero;
  logic [DATA_W-1:0]         wr_rdat_unused;

  assign wdec         = slv_decode(MAX_AW'(REG_WADR), BASE_EXT, MASK_EXT);
  assign rdec         = slv_decode(MAX_AW'(REG_RADR), BASE_EXT, MASK_EXT);
  assign wr_rdat_zero = '0;

  assign S_WADR = REG_WADR;
  assign S_WDAT = REG_WDAT;
  assign S_WENB = REG_WENB;
  assign S_RADR = REG_RADR;

  sc_scbc_regsel_chan #(
    .NUM_SLV    (NUM_SLV),
    .ASYNC_MASK (ASYNC_MASK),
    .TIMEOUT    (TIMEOUT)
  ) u_wr_chan (
    .clk      (SYSCLK),
    .rst_n    (SYSRSTB),
    .req      (|REG_WENB),
    .hit      (wdec.hit),
    .idx      (wdec.idx),
    .ack      (S_WACK),
    .slv_rdat (wr_rdat_zero),
    .sel_c    (S_WSEL),
    .slv_req  (S_WREQ),
    .wat_c    (REG_WWAT),
    .err_c    (REG_WERR),
    .rdat_c   (wr_rdat_unused)
  );

  sc_scbc_regsel_chan #(
    .NUM_SLV    (NUM_SLV),
    .ASYNC_MASK (ASYNC_MASK),
    .TIMEOUT    (TIMEOUT)
  ) u_rd_chan (
    .clk      (SYSCLK),
    .rst_n    (SYSRSTB),
    .req      (REG_RENB),
    .hit      (rdec.hit),
    .idx      (rdec.idx),
    .ack      (S_RACK),
    .slv_rdat (S_RDAT),
    .sel_c    (S_RSEL),
    .slv_req  (S_RREQ),
    .wat_c    (REG_RWAT),
    .err_c    (REG_RERR),
    .rdat_c   (REG_RDAT)
  );

endmodule

// File: tb/tb_sc_scbc_regsel.sv
// Directed bench for sc_scbc_regsel: slaves 0/1 synchronous, 2/3 handshaked, timeout 8.
module tb_sc_scbc_regsel;

  logic         clk, rst_n;
  logic [31:0]  wadr, wdat, radr;
  logic [3:0]   wenb;
  logic         renb;
  logic         wwat, werr, rwat, rerr;
  logic [31:0]  rdat;
  logic [3:0]   wsel, wreq, wack, rsel, rreq, rack, s_wenb;
  logic [31:0]  s_wadr, s_wdat, s_radr;
  logic [127:0] s_rdat;
  int           checks, failures;

  sc_scbc_regsel #(
    .ADDR_WIDTH (32),
    .NUM_SLV    (4),
    .SLV_BASE   ({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .SLV_MASK   ({4{32'h0000_F000}}),
    .ASYNC_MASK (4'b1100),
    .TIMEOUT    (8)
  ) dut (
    .SYSCLK (clk),    .SYSRSTB (rst_n),
    .REG_WADR (wadr), .REG_WENB (wenb), .REG_WDAT (wdat),
    .REG_WWAT (wwat), .REG_WERR (werr),
    .REG_RADR (radr), .REG_RENB (renb), .REG_RDAT (rdat),
    .REG_RWAT (rwat), .REG_RERR (rerr),
    .S_WSEL (wsel), .S_WREQ (wreq), .S_WACK (wack),
    .S_WADR (s_wadr), .S_WDAT (s_wdat), .S_WENB (s_wenb),
    .S_RSEL (rsel), .S_RREQ (rreq), .S_RACK (rack),
    .S_RADR (s_radr), .S_RDAT (s_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; wadr = '0; wdat = '0; wenb = '0; radr = '0; renb = 1'b0;
    wack = '0; rack = '0;
    s_rdat = {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_BEEF};
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wwat !== 1'b0) begin failures++; $display("FAIL reset_wwat got=%b exp=0", wwat); end
    checks++; if (rwat !== 1'b0) begin failures++; $display("FAIL reset_rwat got=%b exp=0", rwat); end
    checks++; if (wreq !== 4'b0) begin failures++; $display("FAIL reset_wreq got=%b exp=0000", wreq); end
    checks++; if (rreq !== 4'b0) begin failures++; $display("FAIL reset_rreq got=%b exp=0000", rreq); end
    checks++; if (werr !== 1'b0 || rerr !== 1'b0) begin failures++; $display("FAIL reset_err got=%b%b exp=00", werr, rerr); end
    checks++; if (rdat !== 32'h0) begin failures++; $display("FAIL reset_rdat got=%h exp=0", rdat); end
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_sync_write();
    step();
    wadr = 32'h0000_0004; wdat = 32'hA5A5_A5A5; wenb = 4'hF;
    #2;
    checks++; if (wsel !== 4'b0001) begin failures++; $display("FAIL sync_wr_wsel got=%b exp=0001", wsel); end
    checks++; if (wwat !== 1'b0 || werr !== 1'b0) begin failures++; $display("FAIL sync_wr_status got=wat%b err%b exp=wat0 err0", wwat, werr); end
    checks++; if (s_wdat !== 32'hA5A5_A5A5 || s_wadr !== 32'h4 || s_wenb !== 4'hF) begin
      failures++; $display("FAIL sync_wr_bus got=%h/%h/%h exp=a5a5a5a5/4/f", s_wdat, s_wadr, s_wenb); end
    step();
    wenb = 4'h0;
    #2;
    checks++; if (wsel !== 4'b0000 || wreq !== 4'b0000) begin failures++; $display("FAIL sync_wr_idle got=sel%b req%b exp=0000", wsel, wreq); end
  endtask

  task automatic test_sync_read();
    step();
    radr = 32'h0000_1008; renb = 1'b1;
    #2;
    checks++; if (rsel !== 4'b0010) begin failures++; $display("FAIL sync_rd_rsel got=%b exp=0010", rsel); end
    checks++; if (rdat !== 32'hCAFE_F00D || rwat !== 1'b0 || rerr !== 1'b0) begin
      failures++; $display("FAIL sync_rd_data got=%h wat%b err%b exp=cafef00d wat0 err0", rdat, rwat, rerr); end
    step();
    renb = 1'b0;
  endtask

  task automatic test_handshake_read();
    logic [3:0] exp_req;
    logic       exp_wat;
    for (int c = 0; c <= 6; c++) begin
      step();
      radr = (c == 6) ? 32'h0000_0000 : 32'h0000_2010;
      renb = 1'b1;
      rack = (c == 4) ? 4'b0100 : 4'b0000;
      #2;
      exp_req = (c >= 1 && c <= 4) ? 4'b0100 : 4'b0000;
      exp_wat = (c <= 4);
      checks++; if (rreq !== exp_req) begin failures++; $display("FAIL hs_rd_rreq c=%0d got=%b exp=%b", c, rreq, exp_req); end
      checks++; if (rwat !== exp_wat) begin failures++; $display("FAIL hs_rd_rwat c=%0d got=%b exp=%b", c, rwat, exp_wat); end
      if (c == 5) begin
        checks++; if (rdat !== 32'h1234_5678 || rerr !== 1'b0) begin
          failures++; $display("FAIL hs_rd_done got=%h err%b exp=12345678 err0", rdat, rerr); end
      end
      if (c == 6) begin
        checks++; if (rdat !== 32'h0BAD_BEEF || rsel !== 4'b0001) begin
          failures++; $display("FAIL back_to_back_rd got=%h sel%b exp=0badbeef sel0001", rdat, rsel); end
      end
    end
    step();
    renb = 1'b0;
  endtask

  task automatic test_timeout();
    logic [3:0] exp_req;
    logic       exp_wat;
    for (int c = 0; c <= 13; c++) begin
      step();
      radr = (c == 13) ? 32'h0000_0000 : 32'h0000_3000;
      renb = (c <= 9 || c == 13);
      rack = (c == 3) ? 4'b0100 : (c == 12) ? 4'b1000 : 4'b0000;
      #2;
      exp_req = (c >= 1 && c <= 8) ? 4'b1000 : 4'b0000;
      exp_wat = (c <= 8);
      checks++; if (rreq !== exp_req) begin failures++; $display("FAIL tmo_rreq c=%0d got=%b exp=%b", c, rreq, exp_req); end
      checks++; if (rwat !== exp_wat) begin failures++; $display("FAIL tmo_rwat c=%0d got=%b exp=%b", c, rwat, exp_wat); end
      if (c == 9) begin
        checks++; if (rerr !== 1'b1 || rdat !== 32'h0) begin
          failures++; $display("FAIL tmo_done got=err%b %h exp=err1 00000000", rerr, rdat); end
      end
      if (c == 12) begin
        checks++; if (rerr !== 1'b0) begin failures++; $display("FAIL tmo_late_ack got=err%b exp=err0", rerr); end
      end
      if (c == 13) begin
        checks++; if (rdat !== 32'h0BAD_BEEF || rerr !== 1'b0) begin
          failures++; $display("FAIL tmo_after got=%h err%b exp=0badbeef err0", rdat, rerr); end
      end
    end
    step();
    renb = 1'b0;
  endtask

  task automatic test_ack_at_timeout();
    logic [3:0] exp_req;
    logic       exp_wat;
    for (int c = 0; c <= 9; c++) begin
      step();
      wadr = 32'h0000_3000; wenb = 4'hF;
      wack = (c == 8) ? 4'b1000 : 4'b0000;
      #2;
      exp_req = (c >= 1 && c <= 8) ? 4'b1000 : 4'b0000;
      exp_wat = (c <= 8);
      checks++; if (wreq !== exp_req) begin failures++; $display("FAIL ack_tmo_wreq c=%0d got=%b exp=%b", c, wreq, exp_req); end
      checks++; if (wwat !== exp_wat) begin failures++; $display("FAIL ack_tmo_wwat c=%0d got=%b exp=%b", c, wwat, exp_wat); end
      if (c == 9) begin
        checks++; if (werr !== 1'b0) begin failures++; $display("FAIL ack_tmo_err got=%b exp=0", werr); end
      end
    end
    step();
    wenb = 4'h0;
  endtask

  task automatic test_unmapped();
    step();
    wadr = 32'h0000_F000; wenb = 4'h3;
    radr = 32'h0000_8000; renb = 1'b1;
    #2;
    checks++; if (wwat !== 1'b0 || werr !== 1'b1 || wsel !== 4'b0) begin
      failures++; $display("FAIL unmapped_wr got=wat%b err%b sel%b exp=wat0 err1 sel0000", wwat, werr, wsel); end
    checks++; if (rwat !== 1'b0 || rerr !== 1'b1 || rdat !== 32'h0 || rsel !== 4'b0) begin
      failures++; $display("FAIL unmapped_rd got=wat%b err%b %h sel%b exp=wat0 err1 0 sel0000", rwat, rerr, rdat, rsel); end
    step();
    wenb = 4'h0; renb = 1'b0;
    #2;
    checks++; if (wreq !== 4'b0 || rreq !== 4'b0 || werr !== 1'b0) begin
      failures++; $display("FAIL unmapped_after got=wreq%b rreq%b err%b exp=0000 0000 0", wreq, rreq, werr); end
  endtask

  task automatic test_concurrent();
    logic [3:0] exp_wreq, exp_rreq;
    logic       exp_wwat, exp_rwat;
    for (int c = 0; c <= 5; c++) begin
      step();
      wadr = 32'h0000_2000; wenb = (c <= 3) ? 4'hF : 4'h0;
      radr = 32'h0000_2004; renb = 1'b1;
      wack = (c == 2) ? 4'b0100 : 4'b0000;
      rack = (c == 4) ? 4'b0100 : 4'b0000;
      #2;
      exp_wreq = (c >= 1 && c <= 2) ? 4'b0100 : 4'b0000;
      exp_rreq = (c >= 1 && c <= 4) ? 4'b0100 : 4'b0000;
      exp_wwat = (c <= 2);
      exp_rwat = (c <= 4);
      checks++; if (wreq !== exp_wreq || rreq !== exp_rreq) begin
        failures++; $display("FAIL conc_req c=%0d got=%b/%b exp=%b/%b", c, wreq, rreq, exp_wreq, exp_rreq); end
      checks++; if (wwat !== exp_wwat || rwat !== exp_rwat) begin
        failures++; $display("FAIL conc_wat c=%0d got=%b/%b exp=%b/%b", c, wwat, rwat, exp_wwat, exp_rwat); end
      if (c == 3) begin
        checks++; if (werr !== 1'b0) begin failures++; $display("FAIL conc_werr got=%b exp=0", werr); end
      end
      if (c == 5) begin
        checks++; if (rdat !== 32'h1234_5678 || rerr !== 1'b0) begin
          failures++; $display("FAIL conc_rd got=%h err%b exp=12345678 err0", rdat, rerr); end
      end
    end
    step();
    renb = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    wadr = 32'h0000_2000; wenb = 4'hF;
    step();
    #2;
    checks++; if (wreq !== 4'b0100) begin failures++; $display("FAIL rst_mid_pre got=%b exp=0100", wreq); end
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (wreq !== 4'b0000) begin failures++; $display("FAIL rst_mid_wreq got=%b exp=0000", wreq); end
    step();
    rst_n = 1'b1;
    #2;
    checks++; if (wwat !== 1'b1 || wreq !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_idle got=wat%b req%b exp=wat1 req0000", wwat, wreq); end
    step();
    wack = 4'b0100;
    #2;
    checks++; if (wreq !== 4'b0100) begin failures++; $display("FAIL rst_mid_redecode got=%b exp=0100", wreq); end
    step();
    wack = 4'b0000;
    #2;
    checks++; if (wwat !== 1'b0 || werr !== 1'b0) begin
      failures++; $display("FAIL rst_mid_done got=wat%b err%b exp=wat0 err0", wwat, werr); end
    step();
    wenb = 4'h0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sync_write();
    test_sync_read();
    test_handshake_read();
    test_timeout();
    test_ack_at_timeout();
    test_unmapped();
    test_concurrent();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
